if_stage: RTL and testbench

Instruction fetch stage: owns the program counter and issues in-order word fetches to the instruction memory. It buffers returned words in a small FIFO and presents them, with their PC, to the decode stage through a valid/ready handshake. `out_instruction` drives the decoder's instruction input directly. The execute stage can redirect the PC on a taken branch or jump, which flushes the FIFO and all in-flight fetches.

---
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, in-order fetch requests, response FIFO to decode
// Optional misaligned-redirect tagging is built when IF_MISALIGN_CHECK_EN is defined.
module if_stage #(
    parameter int                    INSTRUCTON_WIDTH = 32,
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0,
    parameter int                    FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [ADDR_WIDTH-1:0]       imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [INSTRUCTON_WIDTH-1:0] imem_rsp_data,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTON_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    output logic                        out_misaligned
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [CW-1:0]               outstanding_q, outstanding_d;
    logic [CW-1:0]               drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
    logic [INSTRUCTON_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]       pcmem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]       shadow_q [FIFO_DEPTH];
    logic                        req_fire, pop, push, credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit uses registered counts only, so a pop this cycle does not free a slot until the next.
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_valid      = (fifo_cnt_q != '0);
    assign pop            = out_valid && out_ready;
    assign out_instruction = data_q[rd_ptr_q];
    assign out_pc          = pcmem_q[rd_ptr_q];

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_cnt_d    = fifo_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        sh_rd_d       = sh_rd_q;
        sh_wr_d       = sh_wr_q;
        push          = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight becomes garbage; the response landing now is already discarded.
            pc_d          = redirect_pc;
            outstanding_d = outstanding_q - CW'(imem_rsp_valid);
            drop_cnt_d    = outstanding_q - CW'(imem_rsp_valid);
            fifo_cnt_d    = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            sh_rd_d       = '0;
            sh_wr_d       = '0;
        end else begin
            if (req_fire) begin
                pc_d    = pc_q + ADDR_WIDTH'(4);
                sh_wr_d = ptr_inc(sh_wr_q);
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    push    = 1'b1;
                    sh_rd_d = ptr_inc(sh_rd_q);
                end
            end
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
            fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            sh_rd_q       <= '0;
            sh_wr_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i]   <= '0;
                pcmem_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            sh_rd_q       <= sh_rd_d;
            sh_wr_q       <= sh_wr_d;
            if (push) begin
                data_q[wr_ptr_q]  <= imem_rsp_data;
                pcmem_q[wr_ptr_q] <= shadow_q[sh_rd_q];
            end
            if (req_fire) shadow_q[sh_wr_q] <= pc_q;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic mis_mem_q [FIFO_DEPTH];

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mis_mem_q[i] <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            if (push) mis_mem_q[wr_ptr_q] <= misalign_q;
        end
    end

    assign out_misaligned = mis_mem_q[rd_ptr_q];
`else
    assign out_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with a fixed-latency memory model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready, out_misaligned;
    logic [31:0] out_instruction, out_pc;

    always #5 clk = ~clk;

    if_stage #(.INSTRUCTON_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_misaligned(out_misaligned)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; logic mis; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        m_q[$];
    logic [31:0] m_sh[$];
    int          m_out, m_drop;
    logic [31:0] m_req_pc;
    logic        m_mis;
    mreq_t       mem_q[$];
    int          lat, cyc_n, n_chk, n_err;
    logic [31:0] dlv_pc[$];
    int          dlv_cyc[$];
    logic        dlv_mis[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic        exp_mis_flag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [31:0] dpc(input int i);
        return (i < dlv_pc.size()) ? dlv_pc[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic int dcyc(input int i);
        return (i < dlv_cyc.size()) ? dlv_cyc[i] : -1;
    endfunction
    function automatic logic [31:0] rlog(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input int latency);
        rst_n = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_req_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instruction, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_mis", 32'(out_misaligned), 32'd0);
        @(posedge clk); #1;
        m_q.delete(); m_sh.delete(); mem_q.delete();
        dlv_pc.delete(); dlv_cyc.delete(); dlv_mis.delete(); req_log.delete(); req_cyc.delete();
        m_out = 0; m_drop = 0; m_req_pc = 32'h0; m_mis = 1'b0;
        lat = latency; cyc_n = 0;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare against the model at the falling edge, then advance the model.
    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
        mreq_t t;
        logic  exp_rv, pop;
        out_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc_n) begin
            t = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = t.addr ^ 32'h13;
        end
        @(negedge clk);
        exp_rv = !rd && (m_out + m_q.size() < 4);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_req_pc);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_instr", out_instruction, m_q[0].data);
            chk("out_mis", 32'(out_misaligned), 32'(m_q[0].mis));
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back('{imem_req_addr, cyc_n + lat});
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc_n);
        end
        pop = (m_q.size() > 0) && rdy;
        if (pop) begin
            dlv_pc.push_back(out_pc); dlv_cyc.push_back(cyc_n); dlv_mis.push_back(out_misaligned);
            chk("pop_data_rel", out_instruction, out_pc ^ 32'h13);
            void'(m_q.pop_front());
        end
        if (rd) begin
            m_out  = m_out - (imem_rsp_valid ? 1 : 0);
            m_drop = m_out;
            m_q.delete(); m_sh.delete();
            m_req_pc = rpc;
`ifdef IF_MISALIGN_CHECK_EN
            m_mis = (rpc[1:0] != 2'b00);
`endif
        end else begin
            if (exp_rv && imem_req_ready) begin
                m_sh.push_back(m_req_pc);
                m_req_pc = m_req_pc + 32'd4;
                m_out++;
            end
            if (imem_rsp_valid) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else if (m_sh.size() > 0) m_q.push_back('{m_sh.pop_front(), imem_rsp_data, m_mis});
            end
        end
        @(posedge clk); #1;
        cyc_n++;
    endtask

    initial begin
        int nreq;
        n_chk = 0; n_err = 0; cyc_n = 0;
`ifdef IF_MISALIGN_CHECK_EN
        exp_mis_flag = 1'b1;
`else
        exp_mis_flag = 1'b0;
`endif

        // Streaming from reset with a 1-cycle memory.
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0);
        chk("t1_req0", rlog(0), 32'h0);
        chk("t1_req1", rlog(1), 32'h4);
        chk("t1_req2", rlog(2), 32'h8);
        chk("t1_req2_cyc", 32'(req_cyc.size() > 2 ? req_cyc[2] : -1), 32'd2);
        chk("t1_dlv0", dpc(0), 32'h0);
        chk("t1_dlv2", dpc(2), 32'h8);
        chk("t1_dlv0_cyc", 32'(dcyc(0)), 32'd2);
        chk("t1_dlv2_cyc", 32'(dcyc(2)), 32'd4);
        chk("t1_count", 32'(dlv_pc.size()), 32'd8);

        // Backpressure: credits stop requests at four, nothing lost on release.
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0);
        nreq = req_log.size();
        chk("t2_req_stop", 32'(nreq), 32'd4);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) chk("t2_order", dpc(i), 32'(4 * i));
        chk("t2_first_cyc", 32'(dcyc(0)), 32'd10);

        // Redirect with two fetches outstanding on a 3-cycle memory.
        do_reset(3);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("t3_outstanding", 32'(m_out), 32'd2);
        cyc(1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, '0);
        chk("t3_dlv0", dpc(0), 32'h100);
        chk("t3_dlv1", dpc(1), 32'h104);
        chk("t3_dlv0_cyc", 32'(dcyc(0)), 32'd7);

        // Redirect coinciding with a response and a pop.
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 32'h200);
        chk("t4_after_redir_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, '0);
        chk("t4_dlv1", dpc(1), 32'h4);
        chk("t4_dlv2", dpc(2), 32'h200);
        chk("t4_dlv2_cyc", 32'(dcyc(2)), 32'd6);

        // Address wrap at the top of the space.
        do_reset(1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0);
        chk("t5_req0", rlog(0), 32'hFFFF_FFFC);
        chk("t5_req1", rlog(1), 32'h0);
        chk("t5_dlv1", dpc(1), 32'h0);

        // Misaligned redirect tagging.
        do_reset(1);
        cyc(1'b1, 1'b1, 32'h102);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0);
        chk("t6_dlv0", dpc(0), 32'h102);
        chk("t6_mis0", 32'(dlv_mis.size() > 0 ? dlv_mis[0] : 1'bx), 32'(exp_mis_flag));
        chk("t6_dlv3", dpc(3), 32'h200);
        chk("t6_mis3", 32'(dlv_mis.size() > 3 ? dlv_mis[3] : 1'bx), 32'd0);

        // Asynchronous reset mid-stream.
        cyc(1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        chk("t7_async_valid", 32'(out_valid), 32'd0);
        chk("t7_async_req", 32'(imem_req_valid), 32'd0);
        do_reset(1);
        cyc(1'b1, 1'b0, '0);
        chk("t7_restart_req", rlog(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
